// File: rtl/hazard_controller.sv
// Hazard sequencer for the 5-stage core: load-use bubbles, taken-branch flushes,
// data-memory wait freezes, and a saturating stall-cycle counter.
module hazard_controller #(
    parameter int LU_BUBBLES   = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic [4:0]       rd_ex,
    input  logic             mem_read_ex,
    input  logic             branch_taken_ex,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             control_sel,
    output logic             if_id_flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_count
);

    localparam int MAXP   = (LU_BUBBLES > FLUSH_CYCLES) ? LU_BUBBLES : FLUSH_CYCLES;
    localparam int CNTR_W = (MAXP > 2) ? $clog2(MAXP) : 1;

    localparam logic [CNTR_W-1:0] LU_LOAD = (LU_BUBBLES > 1) ? CNTR_W'(LU_BUBBLES - 2) : '0;
    localparam logic [CNTR_W-1:0] FL_LOAD = (FLUSH_CYCLES > 1) ? CNTR_W'(FLUSH_CYCLES - 2) : '0;
    localparam logic [CNT_W-1:0]  SAT     = '1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNTR_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic              load_use;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign load_use = mem_read_ex && (rd_ex != 5'd0) &&
                      ((rs1_used && (rs1_id == rd_ex)) || (rs2_used && (rs2_id == rd_ex)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        control_sel = 1'b0;
        if_id_flush = 1'b0;
        pipe_hold   = 1'b0;

        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            control_sel = 1'b1;
            if_id_flush = 1'b1;
            state_d     = RUN;
            cnt_d       = '0;
        end else if (dmem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
        end else if (branch_taken_ex) begin
            // Taken branch wins over any pending load-use bubble and restarts a flush
            control_sel = 1'b1;
            if_id_flush = 1'b1;
            state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            cnt_d       = FL_LOAD;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        control_sel = 1'b1;
                        state_d     = (LU_BUBBLES > 1) ? LU_STALL : RUN;
                        cnt_d       = LU_LOAD;
                    end
                end
                LU_STALL: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    control_sel = 1'b1;
                    if (cnt_q == '0) state_d = RUN;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                FLUSH: begin
                    control_sel = 1'b1;
                    if_id_flush = 1'b1;
                    if (cnt_q == '0) state_d = RUN;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end

        stall_count_d = stall_count_q;
        if (!pc_write && (stall_count_q != SAT)) stall_count_d = stall_count_q + 1'b1;
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: three parameterisations share one stimulus stream;
// a table of single-cycle vectors plus hand-written multi-cycle sequences.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rs1_id = '0, rs2_id = '0, rd_ex = '0;
    logic        rs1_used = 1'b0, rs2_used = 1'b0, mem_read_ex = 1'b0;
    logic        branch_taken_ex = 1'b0, dmem_busy = 1'b0;

    logic        a_pc, a_ifid, a_csel, a_fl, a_hold;
    logic        b_pc, b_ifid, b_csel, b_fl, b_hold;
    logic        c_pc, c_ifid, c_csel, c_fl, c_hold;
    logic [15:0] a_cnt, b_cnt;
    logic [3:0]  c_cnt;

    always #5 clk = ~clk;

    hazard_controller #(.LU_BUBBLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex), .dmem_busy(dmem_busy),
        .pc_write(a_pc), .if_id_write(a_ifid), .control_sel(a_csel),
        .if_id_flush(a_fl), .pipe_hold(a_hold), .stall_count(a_cnt));

    hazard_controller #(.LU_BUBBLES(2), .FLUSH_CYCLES(2), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex), .dmem_busy(dmem_busy),
        .pc_write(b_pc), .if_id_write(b_ifid), .control_sel(b_csel),
        .if_id_flush(b_fl), .pipe_hold(b_hold), .stall_count(b_cnt));

    hazard_controller #(.LU_BUBBLES(3), .FLUSH_CYCLES(1), .CNT_W(4)) u_c (
        .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex), .dmem_busy(dmem_busy),
        .pc_write(c_pc), .if_id_write(c_ifid), .control_sel(c_csel),
        .if_id_flush(c_fl), .pipe_hold(c_hold), .stall_count(c_cnt));

    // Output bundle order: {pc_write, if_id_write, control_sel, if_id_flush, pipe_hold}
    localparam logic [4:0] O_RST  = 5'b00110;
    localparam logic [4:0] O_RUN  = 5'b11000;
    localparam logic [4:0] O_LU   = 5'b00100;
    localparam logic [4:0] O_BR   = 5'b11110;
    localparam logic [4:0] O_BUSY = 5'b00001;

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       busy;
        logic [4:0] exp_o;
        int         exp_cnt;
    } vec_t;

    typedef struct {
        int         inst;
        logic [4:0] exp_o;
        int         exp_cnt;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [4:0] outs(input int inst);
        case (inst)
            0:       return {a_pc, a_ifid, a_csel, a_fl, a_hold};
            1:       return {b_pc, b_ifid, b_csel, b_fl, b_hold};
            default: return {c_pc, c_ifid, c_csel, c_fl, c_hold};
        endcase
    endfunction

    function automatic int cntv(input int inst);
        case (inst)
            0:       return int'(a_cnt);
            1:       return int'(b_cnt);
            default: return int'(c_cnt);
        endcase
    endfunction

    // Shorthand vector: haz drives an rs1 load-use match on x5
    function automatic vec_t V(input logic rst, input logic haz, input logic br,
                               input logic busy, input logic [4:0] eo, input int ec);
        vec_t v;
        v.rst = rst; v.rs1 = haz ? 5'd5 : 5'd0; v.rs2 = 5'd0;
        v.u1 = haz; v.u2 = 1'b0; v.rd = haz ? 5'd5 : 5'd0; v.mr = haz;
        v.br = br; v.busy = busy; v.exp_o = eo; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic cyc(input vec_t v, input int inst, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset = v.rst; rs1_id = v.rs1; rs2_id = v.rs2; rs1_used = v.u1; rs2_used = v.u2;
        rd_ex = v.rd; mem_read_ex = v.mr; branch_taken_ex = v.br; dmem_busy = v.busy;
        e.inst = inst; e.exp_o = v.exp_o; e.exp_cnt = v.exp_cnt; e.name = nm;
        sbq.push_back(e);
        #3;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (outs(e.inst) !== e.exp_o) begin
                errors++;
                $display("FAIL %s outputs{pc,ifid,csel,flush,hold}: got %b expected %b",
                         e.name, outs(e.inst), e.exp_o);
            end
            if (e.exp_cnt >= 0) begin
                checks++;
                if (cntv(e.inst) != e.exp_cnt) begin
                    errors++;
                    $display("FAIL %s stall_count: got %0d expected %0d",
                             e.name, cntv(e.inst), e.exp_cnt);
                end
            end
        end
    endtask

    vec_t tbl[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST,  -1};
        tbl[1]  = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST,   0};
        tbl[2]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN,   0};
        tbl[3]  = '{1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, O_LU,    0};
        tbl[4]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN,   1};
        tbl[5]  = '{1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_RUN,   1};
        tbl[6]  = '{1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, O_RUN,   1};
        tbl[7]  = '{1'b0, 5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, O_LU,    1};
        tbl[8]  = '{1'b0, 5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_RUN,   2};
        tbl[9]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_BR,    2};
        tbl[10] = '{1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, O_BR,    2};
        tbl[11] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_BUSY,  2};
        tbl[12] = '{1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, O_BUSY,  3};
        tbl[13] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN,   4};
        tbl[14] = '{1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, O_RST,   4};
        tbl[15] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN,   0};

        for (int i = 0; i < 16; i++) cyc(tbl[i], 0, $sformatf("tbl[%0d]", i));

        // Two-bubble load-use, then branch+hazard collision with a two-cycle flush
        cyc(V(1, 0, 0, 0, O_RST, -1), 1, "b_rst0");
        cyc(V(1, 0, 0, 0, O_RST,  0), 1, "b_rst1");
        cyc(V(0, 1, 0, 0, O_LU,   0), 1, "b_lu0");
        cyc(V(0, 0, 0, 0, O_LU,   1), 1, "b_lu1");
        cyc(V(0, 0, 0, 0, O_RUN,  2), 1, "b_lu_done");
        cyc(V(0, 1, 1, 0, O_BR,   2), 1, "b_br_lu0");
        cyc(V(0, 0, 0, 0, O_BR,   2), 1, "b_br_lu1");
        cyc(V(0, 0, 0, 0, O_RUN,  2), 1, "b_br_done");
        cyc(V(0, 1, 0, 0, O_LU,   2), 1, "b_abort_lu");
        cyc(V(0, 0, 1, 0, O_BR,   3), 1, "b_abort_br");
        cyc(V(0, 0, 0, 0, O_BR,   3), 1, "b_abort_fl");
        cyc(V(0, 0, 0, 0, O_RUN,  3), 1, "b_abort_done");
        cyc(V(0, 0, 1, 0, O_BR,   3), 1, "b_midfl_br");
        cyc(V(1, 0, 0, 0, O_RST,  3), 1, "b_midfl_rst");
        cyc(V(0, 0, 0, 0, O_RUN,  0), 1, "b_midfl_run");

        // Three-bubble stall interrupted by memory waits, then counter saturation
        cyc(V(1, 0, 0, 0, O_RST, -1), 2, "c_rst0");
        cyc(V(1, 0, 0, 0, O_RST,  0), 2, "c_rst1");
        cyc(V(0, 1, 0, 0, O_LU,   0), 2, "c_lu0");
        cyc(V(0, 0, 0, 1, O_BUSY, 1), 2, "c_busy0");
        cyc(V(0, 0, 0, 1, O_BUSY, 2), 2, "c_busy1");
        cyc(V(0, 0, 0, 1, O_BUSY, 3), 2, "c_busy2");
        cyc(V(0, 0, 0, 0, O_LU,   4), 2, "c_lu1");
        cyc(V(0, 0, 0, 0, O_LU,   5), 2, "c_lu2");
        cyc(V(0, 0, 0, 0, O_RUN,  6), 2, "c_lu_done");
        for (int k = 0; k < 20; k++)
            cyc(V(0, 0, 0, 1, O_BUSY, (6 + k > 15) ? 15 : 6 + k), 2, $sformatf("c_sat%0d", k));
        cyc(V(0, 0, 0, 0, O_RUN, 15), 2, "c_sat_hold");
        cyc(V(0, 1, 0, 0, O_LU,  15), 2, "c_midlu_lu");
        cyc(V(1, 0, 0, 0, O_RST, 15), 2, "c_midlu_rst");
        cyc(V(0, 0, 0, 0, O_RUN,  0), 2, "c_midlu_run");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
